// File: rtl/en_burst_gen_if.sv
// Bundle for en_burst_gen: run control and config in, enable/status out.
// EN_BURST_GEN_PAUSE_EN adds the pause request line.
interface en_burst_gen_if #(
  parameter int unsigned ON_W  = 4,
  parameter int unsigned OFF_W = 4,
  parameter int unsigned REP_W = 4
);
  logic             start;
  logic             abort;
  logic [ON_W-1:0]  on_len;
  logic [OFF_W-1:0] off_len;
  logic [REP_W-1:0] rep_cnt;
  logic             enable;
  logic             busy;
  logic             done;
  logic [REP_W-1:0] burst_idx;
`ifdef EN_BURST_GEN_PAUSE_EN
  logic             pause;

  modport master (
    output start, abort, on_len, off_len, rep_cnt, pause,
    input  enable, busy, done, burst_idx
  );
  modport slave (
    input  start, abort, on_len, off_len, rep_cnt, pause,
    output enable, busy, done, burst_idx
  );
`else
  modport master (
    output start, abort, on_len, off_len, rep_cnt,
    input  enable, busy, done, burst_idx
  );
  modport slave (
    input  start, abort, on_len, off_len, rep_cnt,
    output enable, busy, done, burst_idx
  );
`endif
endinterface

// File: rtl/en_burst_gen.sv
// Burst enable generator: rep_cnt bursts of on_len high cycles separated by off_len low cycles.
// Optional EN_BURST_GEN_PAUSE_EN freezes a run while pause is high.
module en_burst_gen #(
  parameter int unsigned ON_W  = 4,
  parameter int unsigned OFF_W = 4,
  parameter int unsigned REP_W = 4
) (
  input logic             clk,
  input logic             reset,
  en_burst_gen_if.slave   bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_ON, ST_OFF, ST_DONE} state_t;

  state_t           r_state;
  logic [ON_W-1:0]  r_on_len;
  logic [ON_W-1:0]  r_on_cnt;
  logic [OFF_W-1:0] r_off_len;
  logic [OFF_W-1:0] r_off_cnt;
  logic [REP_W-1:0] r_rep;
  logic [REP_W-1:0] r_idx;
  logic             r_enable;
  logic             r_busy;
  logic             r_done;
  logic             r_act;

  logic w_run;
  logic w_pz;
  logic w_frz;

  assign w_run = (r_state == ST_ON) || (r_state == ST_OFF);
`ifdef EN_BURST_GEN_PAUSE_EN
  assign w_pz = w_run && bus.pause;
`else
  assign w_pz = 1'b0;
`endif
  // r_act marks whether the current cycle is a live (unpaused) run cycle; only
  // live cycles advance the phase counter, so paused cycles never count.
  assign w_frz = w_run && !r_act;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_on_len  <= '0;
      r_on_cnt  <= '0;
      r_off_len <= '0;
      r_off_cnt <= '0;
      r_rep     <= '0;
      r_idx     <= '0;
      r_enable  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_act     <= 1'b1;
    end else if (bus.abort && w_run) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_enable <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_act    <= 1'b1;
    end else begin
      r_act <= !w_pz;
      case (r_state)
        ST_IDLE: begin
          r_idx <= '0;
          if (bus.start && !bus.abort) begin
            r_on_len  <= bus.on_len;
            r_off_len <= bus.off_len;
            r_rep     <= bus.rep_cnt;
            if ((bus.on_len == '0) || (bus.rep_cnt == '0)) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state  <= ST_ON;
              r_on_cnt <= bus.on_len;
              r_enable <= 1'b1;
              r_busy   <= 1'b1;
            end
          end
        end
        ST_ON: begin
          if (w_frz) begin
            r_enable <= !w_pz;
          end else if (r_on_cnt == ON_W'(1)) begin
            if (r_idx == r_rep - REP_W'(1)) begin
              r_state  <= ST_DONE;
              r_enable <= 1'b0;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
            end else if (r_off_len != '0) begin
              r_state   <= ST_OFF;
              r_off_cnt <= r_off_len;
              r_enable  <= 1'b0;
            end else begin
              r_on_cnt <= r_on_len;
              r_idx    <= r_idx + REP_W'(1);
              r_enable <= !w_pz;
            end
          end else begin
            r_on_cnt <= r_on_cnt - ON_W'(1);
            r_enable <= !w_pz;
          end
        end
        ST_OFF: begin
          if (!w_frz) begin
            if (r_off_cnt == OFF_W'(1)) begin
              r_state  <= ST_ON;
              r_on_cnt <= r_on_len;
              r_idx    <= r_idx + REP_W'(1);
              r_enable <= !w_pz;
            end else begin
              r_off_cnt <= r_off_cnt - OFF_W'(1);
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_idx   <= '0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.enable    = r_enable;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.burst_idx = r_idx;
endmodule

// File: tb/tb_en_burst_gen.sv
// Scoreboard bench for en_burst_gen: expected per-cycle traces come from a
// burst-list model; a negedge monitor pops and compares.
module tb_en_burst_gen;
  localparam int unsigned ON_W  = 4;
  localparam int unsigned OFF_W = 4;
  localparam int unsigned REP_W = 4;

  typedef logic [REP_W+2:0] obs_t;  // {enable, busy, done, burst_idx}

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  en_burst_gen_if #(.ON_W(ON_W), .OFF_W(OFF_W), .REP_W(REP_W)) bus ();
  en_burst_gen #(.ON_W(ON_W), .OFF_W(OFF_W), .REP_W(REP_W)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  obs_t exp_q[$];
  int   tot_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;
  int   en_cnt   = 0;
  obs_t act;
  obs_t expv;
  int   tot;

  function automatic obs_t mk(bit en, bit bz, bit dn, int idx);
    return {en, bz, dn, REP_W'(idx)};
  endfunction

  task automatic chk(input string nm, input obs_t a, input obs_t e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got en=%0b busy=%0b done=%0b idx=%0d, required en=%0b busy=%0b done=%0b idx=%0d",
               nm, a[REP_W+2], a[REP_W+1], a[REP_W], a[REP_W-1:0],
               e[REP_W+2], e[REP_W+1], e[REP_W], e[REP_W-1:0]);
    end
  endtask

  // Monitor: pops one expected entry per run cycle, checks idle otherwise.
  always @(negedge clk) begin
    if (mon_en) begin
      act = {bus.enable, bus.busy, bus.done, bus.burst_idx};
      if (bus.busy || bus.done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got %h, required idle outputs", act);
        end else begin
          expv = exp_q.pop_front();
          chk("run_cycle", act, expv);
        end
      end else begin
        chk("idle", act, '0);
      end
      if (bus.enable) en_cnt++;
      if (bus.done) begin
        n_checks++;
        if (tot_q.size() == 0) begin
          n_fail++;
          $display("FAIL enable_total: got done pulse, required none");
        end else begin
          tot = tot_q.pop_front();
          if (en_cnt != tot) begin
            n_fail++;
            $display("FAIL enable_total: got %0d, required %0d", en_cnt, tot);
          end
        end
        en_cnt = 0;
      end else if (!bus.busy) begin
        en_cnt = 0;
      end
    end
  end

  task automatic rand_cfg();
    bus.on_len  = ON_W'($urandom);
    bus.off_len = OFF_W'($urandom);
    bus.rep_cnt = REP_W'($urandom);
  endtask

  // Called at posedge+1. kind: 0 none, 1 abort, 2 reset, 3 abort during DONE.
  task automatic run(input int on, input int off, input int rep,
                     input int kill_at, input int kind, input int restart_at);
    obs_t lst[$];
    int   n;
    if (on == 0 || rep == 0) begin
      lst.push_back(mk(0, 0, 1, 0));
    end else begin
      for (int b = 0; b < rep; b++) begin
        for (int i = 0; i < on; i++) lst.push_back(mk(1, 1, 0, b));
        if (b < rep - 1)
          for (int i = 0; i < off; i++) lst.push_back(mk(0, 1, 0, b));
      end
      lst.push_back(mk(0, 0, 1, rep - 1));
    end
    if (kind == 1 || kind == 2) begin
      while (lst.size() > kill_at + 1) void'(lst.pop_back());
    end else begin
      tot_q.push_back(on * rep);
    end
    n = lst.size();
    bus.start   = 1'b1;
    bus.on_len  = ON_W'(on);
    bus.off_len = OFF_W'(off);
    bus.rep_cnt = REP_W'(rep);
    foreach (lst[i]) exp_q.push_back(lst[i]);
    @(posedge clk); #1;
    bus.start = 1'b0;
    rand_cfg();
    for (int c = 0; c < n; c++) begin
      if (c == kill_at && kind != 2) bus.abort = 1'b1;
      if (c == kill_at && kind == 2) reset = 1'b1;
      if (c == restart_at) bus.start = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      bus.start = 1'b0;
      reset     = 1'b0;
      rand_cfg();
    end
    for (int t = 0; t < 20 && (exp_q.size() != 0 || tot_q.size() != 0); t++) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (exp_q.size() != 0 || tot_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d cycles and %0d done pulses outstanding, required 0",
               exp_q.size(), tot_q.size());
      exp_q.delete();
      tot_q.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int on, off, rep, len, kind, kat, rst;
    reset       = 1'b1;
    bus.start   = 1'b1;
    bus.abort   = 1'b0;
    bus.on_len  = 4'd3;
    bus.off_len = 4'd2;
    bus.rep_cnt = 4'd2;
`ifdef EN_BURST_GEN_PAUSE_EN
    bus.pause   = 1'b0;
`endif
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    reset     = 1'b0;
    bus.start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    run(3, 2, 2, -1, 0, -1);
    run(4, 0, 3, -1, 0, 5);
    run(0, 3, 5, -1, 0, -1);
    run(2, 1, 0, -1, 0, -1);
    run(2, 3, 4, 3, 1, -1);
    run(1, 0, 1, -1, 0, -1);
    run(3, 2, 2, 1, 2, -1);
    run(15, 1, 2, -1, 0, -1);
    run(2, 15, 2, -1, 0, 4);
    run(1, 1, 1, 1, 3, -1);
    run(3, 2, 2, -1, 0, 8);

    bus.start = 1'b1;
    bus.abort = 1'b1;
    bus.on_len = 4'd2;
    bus.rep_cnt = 4'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    for (int r = 0; r < 40; r++) begin
      on   = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 6);
      off  = $urandom_range(0, 4);
      rep  = $urandom_range(0, 4);
      len  = (on == 0 || rep == 0) ? 1 : rep * on + (rep - 1) * off + 1;
      kind = $urandom_range(0, 5);
      kind = (kind < 3) ? 0 : kind - 2;
      if (len == 1 && kind != 3) kind = 0;
      kat  = (kind == 3) ? len - 1 : ((kind != 0) ? $urandom_range(0, len - 2) : -1);
      rst  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, len - 1) : -1;
      run(on, off, rep, kat, kind, rst);
      if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
    end

    repeat (3) begin @(posedge clk); #1; end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/en_burst_gen.md
Name: en_burst_gen

Overview:
Upstream stimulus/control stage that drives the enable input of the 4-bit counter stage. On a start request it emits a programmable enable pattern: rep_cnt bursts, each on_len cycles high, separated by off_len cycles low. It then reports completion. Enable is registered and glitch-free, so the downstream counter sees exactly rep_cnt*on_len enabled edges per run.

Parameters:
ON_W, 4, width of on_len and of the ON-phase cycle counter
OFF_W, 4, width of off_len and of the OFF-phase cycle counter
REP_W, 4, width of rep_cnt and burst_idx

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  run request, sampled only in IDLE
abort  input  1  terminate run, no done pulse
on_len  input  ON_W  enable-high cycles per burst, latched on accepted start
off_len  input  OFF_W  enable-low cycles between bursts, latched on accepted start
rep_cnt  input  REP_W  number of bursts, latched on accepted start
enable  output  1  registered enable to downstream counter
busy  output  1  high in ON and OFF states
done  output  1  one-cycle pulse when a run completes normally
burst_idx  output  REP_W  index of current burst, 0..rep_cnt-1

Behaviour:
- Clocking: the single clock is clk. reset is synchronous and active-high. All state changes occur on the rising edge of clk.
- Reset: state=IDLE; enable=0, busy=0, done=0, burst_idx=0; latched config cleared. Reset overrides start and abort.
- FSM states: IDLE, ON, OFF, DONE.
- IDLE:
  - start=1 with abort=0 latches on_len/off_len/rep_cnt.
  - If latched on_len==0 or rep_cnt==0, go to DONE (done pulse, no enable cycles).
  - Otherwise go to ON.
  - abort has priority over start: in IDLE with both high, start is ignored.
- ON:
  - enable=1, busy=1.
  - Phase counter runs on_len cycles.
  - On the last ON cycle: if burst_idx==rep_cnt-1, go to DONE.
  - Else, if off_len>0, go to OFF.
  - Else (off_len==0), re-enter ON with burst_idx+1; enable stays continuously high and bursts merge.
- OFF:
  - enable=0, busy=1.
  - Runs off_len cycles, then goes to ON with burst_idx+1.
- DONE:
  - done=1, busy=0, enable=0 for exactly one cycle, then IDLE.
  - burst_idx returns to 0 on entering IDLE.
- Latency: start sampled at edge k gives enable=1 in the cycle following edge k. done is high in the cycle immediately after the final ON cycle.
- Enable totals: total enable-high cycles per run = rep_cnt*on_len. Total run length = rep_cnt*on_len + (rep_cnt-1)*off_len cycles, plus 1 cycle of DONE.
- Outputs: enable, busy, done and burst_idx are all decoded from registered state. No combinational path from inputs to outputs.
- Restart rules: start while busy or in DONE is ignored. A new start is accepted on the first IDLE cycle after DONE.
- Config stability: on_len/off_len/rep_cnt changes after acceptance have no effect on the current run.
- abort:
  - In ON or OFF: next cycle is IDLE with enable=0, busy=0, done=0, burst_idx=0.
  - In DONE: ignored; the done pulse completes.
- Widths: phase counters are ON_W/OFF_W bits wide and count down from the latched length to 1, with no wrap. Maximum on_len=2^ON_W-1.
- Reset mid-run: next cycle is IDLE with all outputs 0. No done pulse is produced.

Optional Feature:
Macro EN_BURST_GEN_PAUSE_EN.
- Defined: adds input port pause (1 bit).
  - While pause=1 in ON or OFF, the FSM, phase counter and burst_idx freeze, and enable is forced to 0.
  - When pause falls, the run resumes where it stopped. Remaining cycle counts are preserved.
  - pause has no effect in IDLE/DONE.
  - abort and reset override pause.
- Not defined: no pause port; behaviour is exactly as above.

Test Plan:
- Reset and idle: hold reset 2 cycles, then idle -> enable=0, busy=0, done=0, burst_idx=0; start with reset=1 is ignored.
- Basic run: on_len=3, off_len=2, rep_cnt=2, pulse start -> enable sequence 1,1,1,0,0,1,1,1. burst_idx 0,0,0,0,0,1,1,1. done pulse 1 cycle after the last 1. Downstream counter ends at 6.
- Merged bursts: on_len=4, off_len=0, rep_cnt=3 -> enable high 12 consecutive cycles. burst_idx steps 0->1->2 every 4 cycles. Single done pulse.
- Zero-length config: on_len=0, rep_cnt=5, start -> no enable cycles; done=1 in the cycle after start. Likewise for rep_cnt=0.
- Abort mid-OFF: on_len=2, off_len=3, rep_cnt=4, assert abort in the 2nd OFF cycle -> next cycle IDLE, enable=0, busy=0, no done pulse. A new start with on_len=1, rep_cnt=1 gives exactly one enable cycle.
- Ignored start and reset mid-run:
  - start re-pulsed during ON -> run length unchanged.
  - reset asserted mid-ON -> enable=0, burst_idx=0 next cycle, no done pulse.
